// File: rtl/othello_board_engine.sv
// Othello board store and move engine: holds the SIZE x SIZE board, checks a move
// in all eight directions and applies it one captured disk per cycle.
module othello_board_engine #(
    parameter int SIZE    = 8,
    parameter int COORD_W = 3,
    parameter int CNT_W   = 7
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               side,
    input  logic               detect_req,
    input  logic               write_req,
    output logic               busy,
    output logic               done,
    output logic               legal,
    output logic [7:0]         dir,
    output logic [CNT_W-1:0]   flips,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic [1:0]         rd_data,
    output logic [CNT_W-1:0]   count0,
    output logic [CNT_W-1:0]   count1
);
    localparam int CELLS = SIZE * SIZE;
    localparam int IDX_W = $clog2(CELLS);
    localparam int PW    = COORD_W + 2;

    typedef logic [CELLS-1:0][1:0] board_t;
    typedef logic signed [PW-1:0]  pos_t;
    typedef enum logic [2:0] {IDLE, CHECK, SCAN, PLACE, FLIP, DONE} state_t;

    localparam pos_t P_ONE  = pos_t'(1);
    localparam pos_t P_NEG  = pos_t'(-1);
    localparam pos_t SIZE_P = pos_t'(SIZE);

    function automatic board_t init_board();
        board_t b;
        b = '0;
        b[(SIZE/2-1)*SIZE + SIZE/2-1] = 2'd2;
        b[(SIZE/2)*SIZE + SIZE/2]     = 2'd2;
        b[(SIZE/2-1)*SIZE + SIZE/2]   = 2'd3;
        b[(SIZE/2)*SIZE + SIZE/2-1]   = 2'd3;
        return b;
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] cx,
                                                  input logic [COORD_W-1:0] cy);
        return IDX_W'(cy) * IDX_W'(SIZE) + IDX_W'(cx);
    endfunction

    function automatic pos_t step_dx(input logic [2:0] d);
        case (d)
            3'd1, 3'd2, 3'd3: return P_ONE;
            3'd5, 3'd6, 3'd7: return P_NEG;
            default:          return '0;
        endcase
    endfunction

    function automatic pos_t step_dy(input logic [2:0] d);
        case (d)
            3'd0, 3'd1, 3'd7: return P_NEG;
            3'd3, 3'd4, 3'd5: return P_ONE;
            default:          return '0;
        endcase
    endfunction

    function automatic logic on_board(input pos_t px, input pos_t py);
        return !px[PW-1] && !py[PW-1] && (px < SIZE_P) && (py < SIZE_P);
    endfunction

    function automatic logic [2:0] first_dir(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    board_t             board_q, board_d;
    logic [COORD_W-1:0] req_x_q, req_x_d, req_y_q, req_y_d;
    logic               side_q, side_d, write_q, write_d;
    logic [7:0]         dir_q, dir_d, rem_q, rem_d;
    logic [CNT_W-1:0]   flips_q, flips_d, run_q, run_d;
    logic [CNT_W-1:0]   count0_q, count0_d, count1_q, count1_d;
    logic [2:0]         d_q, d_d;
    pos_t               pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [1:0]         rd_data_q, rd_data_d;

    pos_t       base_x, base_y, next_x, next_y;
    logic [1:0] own_cell, opp_cell, probe_cell;
    logic       target_on, target_bad, probe_on, next_opp;
    logic [2:0] nd;

    // Cells the FSM looks at this cycle: the target, the scan probe and the cell past the flip cursor.
    always_comb begin
        base_x     = pos_t'({2'b00, req_x_q});
        base_y     = pos_t'({2'b00, req_y_q});
        own_cell   = {1'b1, side_q};
        opp_cell   = {1'b1, ~side_q};
        target_on  = ({1'b0, req_x_q} < (COORD_W+1)'(SIZE)) &&
                     ({1'b0, req_y_q} < (COORD_W+1)'(SIZE));
        target_bad = target_on ? board_q[cell_idx(req_x_q, req_y_q)][1] : 1'b1;
        probe_on   = on_board(pos_x_q, pos_y_q);
        probe_cell = probe_on ?
                     board_q[cell_idx(pos_x_q[COORD_W-1:0], pos_y_q[COORD_W-1:0])] : 2'b00;
        next_x     = pos_x_q + step_dx(d_q);
        next_y     = pos_y_q + step_dy(d_q);
        next_opp   = on_board(next_x, next_y) &&
                     (board_q[cell_idx(next_x[COORD_W-1:0], next_y[COORD_W-1:0])] == opp_cell);
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        req_x_d   = req_x_q;
        req_y_d   = req_y_q;
        side_d    = side_q;
        write_d   = write_q;
        dir_d     = dir_q;
        rem_d     = rem_q;
        flips_d   = flips_q;
        run_d     = run_q;
        count0_d  = count0_q;
        count1_d  = count1_q;
        d_d       = d_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        nd        = 3'd0;
        rd_data_d = (({1'b0, rd_x} < (COORD_W+1)'(SIZE)) && ({1'b0, rd_y} < (COORD_W+1)'(SIZE))) ?
                    board_q[cell_idx(rd_x, rd_y)] : 2'b00;

        case (state_q)
            IDLE: begin
                if (write_req || detect_req) begin
                    state_d = CHECK;
                    req_x_d = x;
                    req_y_d = y;
                    side_d  = side;
                    write_d = write_req;
                end
            end
            CHECK: begin
                dir_d   = '0;
                flips_d = '0;
                run_d   = '0;
                d_d     = 3'd0;
                pos_x_d = base_x + step_dx(3'd0);
                pos_y_d = base_y + step_dy(3'd0);
                state_d = target_bad ? DONE : SCAN;
            end
            SCAN: begin
                if (probe_on && probe_cell == opp_cell) begin
                    run_d   = run_q + 1'b1;
                    pos_x_d = next_x;
                    pos_y_d = next_y;
                end else begin
                    // An own cell only captures when at least one opponent cell lies before it.
                    if (probe_on && probe_cell[1] && run_q != '0) begin
                        dir_d[d_q] = 1'b1;
                        flips_d    = flips_q + run_q;
                    end
                    if (d_q == 3'd7) begin
                        state_d = (write_q && dir_d != 8'd0) ? PLACE : DONE;
                    end else begin
                        nd      = d_q + 3'd1;
                        d_d     = nd;
                        run_d   = '0;
                        pos_x_d = base_x + step_dx(nd);
                        pos_y_d = base_y + step_dy(nd);
                    end
                end
            end
            PLACE: begin
                board_d[cell_idx(req_x_q, req_y_q)] = own_cell;
                if (side_q) count1_d = count1_q + 1'b1;
                else        count0_d = count0_q + 1'b1;
                nd      = first_dir(dir_q);
                d_d     = nd;
                rem_d   = dir_q & ~(8'd1 << nd);
                pos_x_d = base_x + step_dx(nd);
                pos_y_d = base_y + step_dy(nd);
                state_d = FLIP;
            end
            FLIP: begin
                board_d[cell_idx(pos_x_q[COORD_W-1:0], pos_y_q[COORD_W-1:0])] = own_cell;
                if (side_q) begin
                    count1_d = count1_q + 1'b1;
                    count0_d = count0_q - 1'b1;
                end else begin
                    count0_d = count0_q + 1'b1;
                    count1_d = count1_q - 1'b1;
                end
                // Look one cell ahead so the bracketing own disk costs no extra cycle.
                if (next_opp) begin
                    pos_x_d = next_x;
                    pos_y_d = next_y;
                end else if (rem_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    nd      = first_dir(rem_q);
                    d_d     = nd;
                    rem_d   = rem_q & ~(8'd1 << nd);
                    pos_x_d = base_x + step_dx(nd);
                    pos_y_d = base_y + step_dy(nd);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q   <= IDLE;
            board_q   <= init_board();
            req_x_q   <= '0;
            req_y_q   <= '0;
            side_q    <= 1'b0;
            write_q   <= 1'b0;
            dir_q     <= '0;
            rem_q     <= '0;
            flips_q   <= '0;
            run_q     <= '0;
            count0_q  <= CNT_W'(2);
            count1_q  <= CNT_W'(2);
            d_q       <= '0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            req_x_q   <= req_x_d;
            req_y_q   <= req_y_d;
            side_q    <= side_d;
            write_q   <= write_d;
            dir_q     <= dir_d;
            rem_q     <= rem_d;
            flips_q   <= flips_d;
            run_q     <= run_d;
            count0_q  <= count0_d;
            count1_q  <= count1_d;
            d_q       <= d_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign legal   = |dir_q;
    assign dir     = dir_q;
    assign flips   = flips_q;
    assign rd_data = rd_data_q;
    assign count0  = count0_q;
    assign count1  = count1_q;

endmodule

// File: tb/tb_othello_board_engine.sv
// Randomised bench for othello_board_engine against a plain array model of the
// game rules, with a small SIZE=6 instance for its reset layout and range check.
module tb_othello_board_engine;
    localparam int S  = 8;
    localparam int CW = 3;
    localparam int NW = 7;

    logic          clock = 1'b0;
    logic          resetn;
    logic [CW-1:0] x, y, rd_x, rd_y;
    logic          side, detect_req, write_req;
    logic          busy, done, legal;
    logic [7:0]    dir;
    logic [NW-1:0] flips, count0, count1;
    logic [1:0]    rd_data;

    logic [CW-1:0] x6, y6, rd_x6, rd_y6;
    logic          detect6, busy6, done6, legal6;
    logic [7:0]    dir6;
    logic [5:0]    flips6, count0_6, count1_6;
    logic [1:0]    rd_data6;

    int bd[S][S];
    int n_checks = 0;
    int n_fail   = 0;
    int dxs[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dys[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    always #5 clock = ~clock;

    othello_board_engine #(.SIZE(S), .COORD_W(CW), .CNT_W(NW)) dut (
        .clock(clock), .resetn(resetn), .x(x), .y(y), .side(side),
        .detect_req(detect_req), .write_req(write_req), .busy(busy), .done(done),
        .legal(legal), .dir(dir), .flips(flips), .rd_x(rd_x), .rd_y(rd_y),
        .rd_data(rd_data), .count0(count0), .count1(count1)
    );

    othello_board_engine #(.SIZE(6), .COORD_W(3), .CNT_W(6)) dut6 (
        .clock(clock), .resetn(resetn), .x(x6), .y(y6), .side(1'b0),
        .detect_req(detect6), .write_req(1'b0), .busy(busy6), .done(done6),
        .legal(legal6), .dir(dir6), .flips(flips6), .rd_x(rd_x6), .rd_y(rd_y6),
        .rd_data(rd_data6), .count0(count0_6), .count1(count1_6)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) bd[r][c] = 0;
        bd[S/2-1][S/2-1] = 2;
        bd[S/2][S/2]     = 2;
        bd[S/2-1][S/2]   = 3;
        bd[S/2][S/2-1]   = 3;
    endfunction

    function automatic int count_cells(input int v);
        int n = 0;
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) if (bd[r][c] == v) n++;
        return n;
    endfunction

    // Walk each ray from the target; a direction costs as many cycles as cells it inspects.
    function automatic void eval_move(input int px, input int py, input int ps,
                                      output logic [7:0] mdir, output int mflips,
                                      output int mscan);
        int own, k, cx, cy;
        bit fin;
        own = 2 + ps;
        mdir = '0;
        mflips = 0;
        mscan = 0;
        for (int d = 0; d < 8; d++) begin
            k = 1;
            fin = 0;
            while (!fin) begin
                cx = px + k * dxs[d];
                cy = py + k * dys[d];
                if (cx < 0 || cx >= S || cy < 0 || cy >= S || bd[cy][cx] < 2) fin = 1;
                else if (bd[cy][cx] == own) begin
                    if (k > 1) begin
                        mdir[d] = 1'b1;
                        mflips += k - 1;
                    end
                    fin = 1;
                end else k++;
            end
            mscan += k;
        end
    endfunction

    function automatic void apply_move(input int px, input int py, input int ps,
                                       input logic [7:0] mdir);
        int own, cx, cy;
        own = 2 + ps;
        bd[py][px] = own;
        for (int d = 0; d < 8; d++) begin
            if (mdir[d]) begin
                cx = px + dxs[d];
                cy = py + dys[d];
                while (bd[cy][cx] != own) begin
                    bd[cy][cx] = own;
                    cx += dxs[d];
                    cy += dys[d];
                end
            end
        end
    endfunction

    task automatic read_cell(input int cx, input int cy, output logic [1:0] v);
        rd_x = CW'(cx);
        rd_y = CW'(cy);
        @(posedge clock);
        #1;
        v = rd_data;
    endtask

    task automatic read_cell6(input int cx, input int cy, output logic [1:0] v);
        rd_x6 = CW'(cx);
        rd_y6 = CW'(cy);
        @(posedge clock);
        #1;
        v = rd_data6;
    endtask

    task automatic check_board();
        logic [1:0] v;
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) begin
                read_cell(c, r, v);
                checkOutput($sformatf("cell(%0d,%0d)", c, r), v, bd[r][c]);
            end
        checkOutput("count0", count0, count_cells(2));
        checkOutput("count1", count1, count_cells(3));
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b0;
        model_reset();
    endtask

    // One request from IDLE; optionally pokes a second request while busy.
    task automatic applyStimulus(input bit do_write, input bit also_detect, input bit poke_busy,
                                 input int px, input int py, input int ps, output int lat_obs);
        logic [7:0] mdir;
        int mflips, mscan, lat_exp, n;
        bit bad, got;
        bad = (bd[py][px] >= 2);
        eval_move(px, py, ps, mdir, mflips, mscan);
        if (bad) begin
            mdir = '0;
            mflips = 0;
        end
        lat_exp = bad ? 2 : (mscan + 2 + ((do_write && mdir != 0) ? mflips + 1 : 0));
        x = CW'(px);
        y = CW'(py);
        side = ps[0];
        write_req = do_write;
        detect_req = !do_write || also_detect;
        @(posedge clock);
        #1;
        write_req = 1'b0;
        detect_req = 1'b0;
        checkOutput("busy_accept", busy, 1);
        n = 0;
        got = 0;
        while (!got && n < 300) begin
            @(posedge clock);
            #1;
            n++;
            if (done) got = 1;
            if (poke_busy && n == 1 && !got) begin
                detect_req = 1'b1;
                x = ~x;
                side = ~side;
            end else detect_req = 1'b0;
        end
        detect_req = 1'b0;
        lat_obs = n + 1;
        checkOutput("done_seen", got, 1);
        checkOutput("latency", lat_obs, lat_exp);
        checkOutput("dir", dir, mdir);
        checkOutput("legal", legal, (mdir != 0));
        if (!bad) checkOutput("flips", flips, mflips);
        if (do_write && mdir != 0 && !bad) apply_move(px, py, ps, mdir);
        @(posedge clock);
        #1;
        checkOutput("done_pulse", done, 0);
        checkOutput("busy_idle", busy, 0);
        checkOutput("dir_hold", dir, mdir);
        checkOutput("count0_op", count0, count_cells(2));
        checkOutput("count1_op", count1, count_cells(3));
    endtask

    initial begin
        logic [1:0] v;
        int lat, n, px, py, ps, pick;
        bit got;
        logic [7:0] mdir;
        int mflips, mscan;
        int cand[$];

        x = '0; y = '0; side = 1'b0; detect_req = 1'b0; write_req = 1'b0;
        rd_x = '0; rd_y = '0; x6 = '0; y6 = '0; rd_x6 = '0; rd_y6 = '0; detect6 = 1'b0;
        resetn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b0;
        model_reset();

        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_legal", legal, 0);
        checkOutput("rst_dir", dir, 0);
        checkOutput("rst_flips", flips, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_count0", count0, 2);
        checkOutput("rst_count1", count1, 2);
        read_cell(3, 3, v); checkOutput("rst_33", v, 2);
        read_cell(4, 3, v); checkOutput("rst_43", v, 3);
        read_cell(3, 4, v); checkOutput("rst_34", v, 3);
        read_cell(4, 4, v); checkOutput("rst_44", v, 2);

        read_cell6(2, 2, v); checkOutput("s6_22", v, 2);
        read_cell6(3, 3, v); checkOutput("s6_33", v, 2);
        read_cell6(3, 2, v); checkOutput("s6_32", v, 3);
        read_cell6(2, 3, v); checkOutput("s6_23", v, 3);
        read_cell6(0, 0, v); checkOutput("s6_00", v, 0);
        x6 = 3'd7; y6 = 3'd1; detect6 = 1'b1;
        @(posedge clock);
        #1;
        detect6 = 1'b0;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(posedge clock);
            #1;
            n++;
            if (done6) got = 1;
        end
        checkOutput("s6_done", got, 1);
        checkOutput("s6_latency", n + 1, 2);
        checkOutput("s6_legal", legal6, 0);

        applyStimulus(0, 0, 0, 5, 3, 0, lat);
        checkOutput("tp_det_lat", lat, 11);
        checkOutput("tp_det_dir", dir, 8'h40);
        checkOutput("tp_det_flips", flips, 1);
        check_board();
        applyStimulus(1, 1, 1, 5, 3, 0, lat);
        checkOutput("tp_wr_lat", lat, 13);
        read_cell(5, 3, v); checkOutput("tp_wr_53", v, 2);
        read_cell(4, 3, v); checkOutput("tp_wr_43", v, 2);
        checkOutput("tp_wr_count0", count0, 4);
        checkOutput("tp_wr_count1", count1, 1);
        applyStimulus(1, 0, 0, 3, 3, 1, lat);
        checkOutput("tp_occ_lat", lat, 2);
        checkOutput("tp_occ_legal", legal, 0);
        check_board();
        do_reset();
        applyStimulus(0, 0, 0, 0, 0, 1, lat);
        checkOutput("tp_corner_lat", lat, 10);
        checkOutput("tp_corner_legal", legal, 0);

        for (int i = 0; i < 40; i++) begin
            if (i % 15 == 14) begin
                do_reset();
                check_board();
            end
            ps = int'($urandom_range(0, 1));
            cand.delete();
            for (int r = 0; r < S; r++)
                for (int c = 0; c < S; c++)
                    if (bd[r][c] < 2) begin
                        eval_move(c, r, ps, mdir, mflips, mscan);
                        if (mdir != 0) cand.push_back(r * S + c);
                    end
            if (cand.size() > 0 && $urandom_range(0, 9) < 7) begin
                pick = cand[$urandom_range(0, cand.size() - 1)];
                px = pick % S;
                py = pick / S;
            end else begin
                px = int'($urandom_range(0, S - 1));
                py = int'($urandom_range(0, S - 1));
            end
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 9) < 3,
                          px, py, ps, lat);
            check_board();
        end

        do_reset();
        x = 3'd5; y = 3'd3; side = 1'b0; write_req = 1'b1;
        @(posedge clock);
        #1;
        write_req = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        checkOutput("flip_busy", busy, 1);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("abort_done", done, 0);
        checkOutput("abort_busy", busy, 0);
        resetn = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clock);
            #1;
            checkOutput("abort_no_done", done, 0);
        end
        check_board();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/othello_board_engine.md
# othello_board_engine

Parameterised Othello board store and move engine: holds a SIZE×SIZE board of 2-bit cells and runs a sequential FSM that checks a move in all 8 directions, then optionally places the disk and flips captured runs one cell per cycle. Sits between the game-control FSM, which issues detect/write requests, and the VGA plot scanner, which reads cells through a registered read port.

## Interface
- SIZE, 8: board edge length; even, 4..8.
- COORD_W, 3: coordinate width; 2^COORD_W ≥ SIZE.
- CNT_W, 7: disk-count width; 2^CNT_W > SIZE*SIZE.
- clock  in  1  single clock, rising edge.
- resetn  in  1  synchronous, active-high reset, despite the name.
- x, y  in  COORD_W  move column, row; sampled with the request.
- side  in  1  mover; own cell = {1,side}, opponent = {1,~side}.
- detect_req  in  1  check the move only.
- write_req  in  1  check the move and, if legal, apply it.
- busy  out  1  high from the accept edge until done.
- done  out  1  one-cycle completion pulse.
- legal  out  1  valid with done: dir != 0.
- dir  out  8  capture directions; bit0 up, 1 up-right, 2 right, 3 down-right, 4 down, 5 down-left, 6 left, 7 up-left.
- flips  out  CNT_W  total disks captured, valid with done.
- rd_x, rd_y  in  COORD_W  plot read address.
- rd_data  out  2  cell at (rd_x, rd_y), one-cycle latency.
- count0, count1  out  CNT_W  disks on board for side 0 and side 1.

## Operation
- Cell encoding: 2'b00 or 2'b01 = empty, 2'b10 = side 0, 2'b11 = side 1. Cell index = y*SIZE + x; up = y-1, right = x+1.
- Reset state: all cells empty except (S/2-1,S/2-1) and (S/2,S/2) = 2'd2, and (S/2,S/2-1) and (S/2-1,S/2) = 2'd3. count0 = count1 = 2. All FSM registers are cleared.
- Reset output values: busy, done, legal = 0; dir = 0; flips = 0; rd_data = 0.
- A request is accepted only in IDLE with busy = 0. Requests seen while busy are ignored, not queued. If detect_req and write_req are both high, write wins.
- FSM states: IDLE → CHECK → SCAN → (PLACE → FLIP)? → DONE → IDLE.
- CHECK, 1 cycle:
  - An occupied target cell, or x or y ≥ SIZE, gives dir = 0 and goes straight to DONE.
  - Otherwise dir and flips are cleared.
- SCAN: directions are scanned in order 0..7, one cell per cycle, at step k = 1, 2, ….
  - Step off the board or onto an empty cell: the direction fails.
  - Step 1 holds own colour: the direction fails.
  - Opponent cell: continue to the next step.
  - Own cell at k ≥ 2: set dir[d] and add k-1 to flips.
  - Every direction costs at least 1 cycle, including an immediate off-board step.
- PLACE: entered only on a write with dir != 0. Writes {1,side} at (x,y) in 1 cycle and increments the mover's count.
- FLIP: walks set dir bits in order 0..7 from step 1, writing {1,side} to each opponent cell, one per cycle. Each write increments the mover's count and decrements the opponent's count. The walk stops at the first own cell in each direction.
- Illegal write: SCAN → DONE, board unchanged.
- DONE: pulses done for 1 cycle. dir, legal and flips hold until the next accept.
- Read port: rd_data is registered every cycle from the current board and ignores busy. During FLIP it may show a partially updated board.

## Timing
- L = cycles from the accept edge to the edge at which done is high.
- Detect, or illegal write: L = 1 + S + 1, where S = total SCAN cycles.
- Legal write: L = 1 + S + 1 + flips + 1.
- Occupied or out-of-range target: L = 2.
- Worst-case S = 8*(SIZE-1).
- Reset mid-operation: on the next edge the FSM aborts to IDLE and the board and counts reinitialise. No done pulse is produced.
- count0 + count1 always equals the number of occupied cells after each edge.

## Test plan
- Reset, SIZE=8 → rd (3,3) = 2, (4,3) = 3, (3,4) = 3, (4,4) = 2; count0 = count1 = 2; busy = 0.
- detect_req at (5,3), side=0 → done 11 cycles after accept; dir = 8'h40; legal = 1; flips = 1; board unchanged.
- write_req at (5,3), side=0 → done after 13 cycles; (5,3) = (4,3) = 2; count0 = 4; count1 = 1.
- write_req at (3,3), occupied → done after 2 cycles; legal = 0; dir = 0; counts unchanged. Corner (0,0) from reset → legal = 0 after 1 + 8 + 1 cycles.
- detect_req pulsed while busy, and detect_req together with write_req → the extra request is ignored, and the write is performed.
- resetn during FLIP → no done; initial board restored. SIZE=6 build: reset centre cells at (2,2) and (3,3) = 2, (3,2) and (2,3) = 3.
